jtpang_bank_server: RTL and testbench

// Responder end of the four-bank ROM read protocol used by the ROM slot banks
// (ba*_addr/ba_rd in; ba_ack/ba_dst/ba_dok/ba_rdy/data_read out).

---
 rtl/jtpang_bank_pkg.sv | 17 +
 rtl/jtpang_bank_rr.sv | 29 ++
 rtl/jtpang_bank_server.sv | 147 ++++++++++++++
 tb/tb_jtpang_bank_server.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpang_bank_pkg.sv
// Shared types and constants for the four-bank ROM read server.
package jtpang_bank_pkg;

  localparam int unsigned BANKS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } state_t;

  function automatic logic [BANKS-1:0] bank_onehot(input logic [1:0] idx);
    bank_onehot = '0;
    bank_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/jtpang_bank_rr.sv
// Combinational 4-way round-robin picker: first requester at or after ptr wins.
module jtpang_bank_rr
  import jtpang_bank_pkg::*;
(
  input  logic [BANKS-1:0] req,
  input  logic [1:0]       ptr,
  output logic             valid,
  output logic [BANKS-1:0] grant,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    // Walk from farthest to nearest so the bank closest to ptr overrides.
    for (int k = int'(BANKS) - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    grant = valid ? bank_onehot(idx) : '0;
  end

endmodule

// File: rtl/jtpang_bank_server.sv
// Serves four bank read ports and the download write port over a single
// variable-latency 16-bit memory port, returning tagged read bursts.
module jtpang_bank_server
  import jtpang_bank_pkg::*;
#(
  parameter int unsigned AW    = 22,
  parameter int unsigned BURST = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_dok,
  output logic [3:0]    ba_rdy,
  output logic [15:0]   data_read,
  input  logic          downloading,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  input  logic          prog_we,
  output logic          prog_ack,
  output logic          prog_rdy,
  output logic [AW+1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_mask,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ok
);

  localparam int unsigned CntW = 2;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    bank_q;
  logic [AW-1:0] base_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_nxt;
  logic          cnt_last;

  logic          gnt_valid;
  logic [3:0]    gnt;
  logic [1:0]    gnt_idx;
  logic [AW-1:0] sel_addr;

  jtpang_bank_rr u_rr (
    .req   (ba_rd),
    .ptr   (ptr_q),
    .valid (gnt_valid),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  always_comb begin
    case (gnt_idx)
      2'd0:    sel_addr = ba0_addr;
      2'd1:    sel_addr = ba1_addr;
      2'd2:    sel_addr = ba2_addr;
      default: sel_addr = ba3_addr;
    endcase
  end

  assign cnt_nxt  = cnt_q + CntW'(1);
  assign cnt_last = (cnt_q == CntW'(BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      bank_q    <= 2'd0;
      base_q    <= '0;
      cnt_q     <= '0;
      ba_ack    <= '0;
      ba_dst    <= '0;
      ba_dok    <= '0;
      ba_rdy    <= '0;
      data_read <= '0;
      prog_ack  <= 1'b0;
      prog_rdy  <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_din   <= '0;
      mem_mask  <= '0;
    end else begin
      ba_ack   <= '0;
      ba_dst   <= '0;
      ba_dok   <= '0;
      ba_rdy   <= '0;
      prog_ack <= 1'b0;
      prog_rdy <= 1'b0;
      case (state_q)
        StIdle: begin
          if (prog_we) begin
            prog_ack <= 1'b1;
            mem_wr   <= 1'b1;
            mem_addr <= {prog_ba, prog_addr};
            mem_din  <= prog_data;
            mem_mask <= prog_mask;
            state_q  <= StWr;
          end else if (!downloading && gnt_valid) begin
            ba_ack   <= gnt;
            bank_q   <= gnt_idx;
            base_q   <= sel_addr;
            cnt_q    <= '0;
            mem_rd   <= 1'b1;
            mem_addr <= {gnt_idx, sel_addr};
            ptr_q    <= gnt_idx + 2'd1;
            state_q  <= StRd;
          end
        end
        StRd: begin
          if (mem_ok) begin
            data_read <= mem_dout;
            ba_dok    <= bank_onehot(bank_q);
            if (cnt_q == '0) ba_dst <= bank_onehot(bank_q);
            if (cnt_last) begin
              ba_rdy  <= bank_onehot(bank_q);
              mem_rd  <= 1'b0;
              state_q <= StIdle;
            end else begin
              // Next word goes out with this one's data: no idle cycle on mem_rd.
              cnt_q    <= cnt_nxt;
              mem_addr <= {bank_q, base_q + AW'(cnt_nxt)};
            end
          end
        end
        StWr: begin
          if (mem_ok) begin
            prog_rdy <= 1'b1;
            mem_wr   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpang_bank_server.sv
// Randomized bench for jtpang_bank_server against a transaction-level model.
module tb_jtpang_bank_server;
  localparam int unsigned AW    = 22;
  localparam int unsigned BURST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] ba_addr [4];
  logic [3:0]    ba_rd = '0;
  logic [3:0]    ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0]   data_read;
  logic          downloading = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [1:0]    prog_ba = '0;
  logic [15:0]   prog_data = '0;
  logic [1:0]    prog_mask = '0;
  logic          prog_we = 1'b0;
  logic          prog_ack, prog_rdy;
  logic [AW+1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_mask;
  logic [15:0]   mem_dout = '0;
  logic          mem_ok = 1'b0;

  jtpang_bank_server #(.AW(AW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .ba0_addr(ba_addr[0]), .ba1_addr(ba_addr[1]), .ba2_addr(ba_addr[2]), .ba3_addr(ba_addr[3]),
    .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read), .downloading(downloading),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_mask(mem_mask), .mem_dout(mem_dout), .mem_ok(mem_ok)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference state: rotating pointer, outstanding burst / write, memory contents.
  int             ptr_m = 0;
  bit             busy_m = 0, wr_busy_m = 0;
  int             g_m = 0, k_m = 0;
  logic [AW-1:0]  a_m = '0;
  logic [AW+1:0]  wa_m = '0;
  logic [15:0]    wd_m = '0;
  logic [1:0]     wm_m = '0;
  logic [15:0]    mem_m [logic [AW+1:0]];

  // Memory back-end state and bench controls.
  bit             mem_pend = 0;
  int             mem_rem = 0;
  logic [AW+1:0]  mem_a = '0;
  int             lat_fix = 3;
  bit             gen_rd = 0, gen_prog = 0, gen_dl = 0, spurious = 0, hold_all = 0;

  int             ack_log[$];
  logic [15:0]    word_log[$];
  logic [AW+1:0]  rdaddr_log[$];
  int             n_ack[4] = '{0, 0, 0, 0};
  int             n_rdy = 0, n_prog_rdy = 0;
  logic [AW+1:0]  last_wr_addr = '0;
  logic [17:0]    last_wr_dm = '0;

  function automatic logic [15:0] mem_rdv(input logic [AW+1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h5a5a;
  endfunction

  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    for (int i = 0; i < 4; i++) if (req[(ptr + i) % 4]) return (ptr + i) % 4;
    return 0;
  endfunction

  function automatic logic [AW+1:0] burst_addr();
    logic [1:0] b;
    b = g_m[1:0];
    return {b, a_m + AW'(k_m)};
  endfunction

  // One clock: check what the DUT produced at the last edge, run memory, drive stimulus.
  task automatic cycle();
    logic [3:0]  e_ack, e_dst, e_dok, e_rdy;
    logic        e_pack, e_prdy;
    logic [15:0] e_data;
    logic [15:0] w;
    int          g;
    @(negedge clk);
    e_ack = '0; e_dst = '0; e_dok = '0; e_rdy = '0;
    e_pack = 1'b0; e_prdy = 1'b0; e_data = '0;
    if (rst) begin
      check_val("rst_flags", 32'({ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy,
                                  mem_rd, mem_wr}), '0);
      check_val("rst_data", {data_read, mem_din}, '0);
      check_val("rst_addr", 32'({mem_addr, mem_mask}), '0);
      ptr_m = 0; busy_m = 0; wr_busy_m = 0; mem_pend = 0;
      mem_ok = 1'b0; mem_dout = 16'($urandom);
      return;
    end
    if (!busy_m && !wr_busy_m) begin
      if (prog_we) begin
        e_pack = 1'b1; wr_busy_m = 1;
        wa_m = {prog_ba, prog_addr}; wd_m = prog_data; wm_m = prog_mask;
      end else if (!downloading && ba_rd != 4'b0) begin
        g = rr_pick(ba_rd, ptr_m);
        e_ack[g] = 1'b1; busy_m = 1; g_m = g; a_m = ba_addr[g]; k_m = 0;
        ptr_m = (g + 1) % 4;
      end
    end else if (mem_ok && busy_m) begin
      e_dok[g_m] = 1'b1;
      e_data = mem_rdv(burst_addr());
      if (k_m == 0) e_dst[g_m] = 1'b1;
      if (k_m == BURST - 1) begin e_rdy[g_m] = 1'b1; busy_m = 0; end
      k_m++;
    end else if (mem_ok && wr_busy_m) begin
      e_prdy = 1'b1; wr_busy_m = 0;
    end
    check_val("ack", 32'({ba_ack, prog_ack}), 32'({e_ack, e_pack}));
    check_val("rd_flags", 32'({ba_dst, ba_dok, ba_rdy}), 32'({e_dst, e_dok, e_rdy}));
    check_val("prog_rdy", 32'(prog_rdy), 32'(e_prdy));
    if (e_dok != 4'b0) check_val("data_read", 32'(data_read), 32'(e_data));
    check_val("mem_cmd", 32'({mem_rd, mem_wr}), 32'({busy_m, wr_busy_m}));
    for (int i = 0; i < 4; i++) if (ba_ack[i]) begin ack_log.push_back(i); n_ack[i]++; end
    if (prog_ack) ack_log.push_back(4);
    if (ba_dok != 4'b0) word_log.push_back(data_read);
    if (ba_rdy != 4'b0) n_rdy++;
    if (prog_rdy) n_prog_rdy++;

    // Memory back-end: one command at a time, latency in clocks from first visibility.
    mem_ok = 1'b0;
    mem_dout = 16'($urandom);
    if (!mem_pend && (mem_rd || mem_wr)) begin
      mem_pend = 1;
      mem_rem = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
      mem_a = mem_addr;
      if (mem_rd) begin
        check_val("rd_addr", 32'(mem_addr), 32'(burst_addr()));
        rdaddr_log.push_back(mem_addr);
      end else begin
        check_val("wr_addr", 32'(mem_addr), 32'(wa_m));
        check_val("wr_data", 32'({mem_din, mem_mask}), 32'({wd_m, wm_m}));
        last_wr_addr = mem_addr;
        last_wr_dm = {mem_din, mem_mask};
      end
    end
    if (mem_pend) begin
      mem_rem--;
      if (mem_rem == 0) begin
        mem_ok = 1'b1; mem_pend = 0;
        if (mem_wr) begin
          w = mem_rdv(mem_a);
          if (!mem_mask[0]) w[7:0] = mem_din[7:0];
          if (!mem_mask[1]) w[15:8] = mem_din[15:8];
          mem_m[mem_a] = w;
        end else begin
          mem_dout = mem_rdv(mem_a);
        end
      end
    end else if (spurious && !mem_rd && !mem_wr && $urandom_range(0, 15) == 0) begin
      mem_ok = 1'b1;
    end

    for (int i = 0; i < 4; i++) begin
      if (ba_ack[i] && !hold_all) ba_rd[i] = 1'b0;
      else if (!ba_rd[i] && gen_rd && $urandom_range(0, 5) == 0) begin
        ba_rd[i] = 1'b1;
        ba_addr[i] = ($urandom_range(0, 3) == 0) ? {AW{1'b1}} - AW'($urandom_range(0, 1))
                                                  : AW'($urandom);
      end
    end
    if (prog_ack) prog_we = 1'b0;
    else if (!prog_we && gen_prog && $urandom_range(0, 39) == 0) begin
      prog_we = 1'b1; prog_addr = AW'($urandom); prog_ba = 2'($urandom);
      prog_data = 16'($urandom); prog_mask = 2'($urandom);
    end
    if (gen_dl && $urandom_range(0, 59) == 0) downloading = !downloading;
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((busy_m || wr_busy_m || ba_rd != 4'b0 || prog_we) && n < bound) begin
      cycle();
      n++;
    end
    check_val(tag, 32'({busy_m, wr_busy_m, ba_rd, prog_we}), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ba_rd = '0;
    prog_we = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int got_i, rdy_before, ack0_before, prdy_before, n;
  bit saw;

  initial begin
    for (int i = 0; i < 4; i++) ba_addr[i] = '0;
    do_reset();

    // Single read on bank 2, fixed latency 3.
    mem_m[24'h801234] = 16'hA1B2;
    mem_m[24'h801235] = 16'hC3D4;
    ack_log.delete(); word_log.delete();
    ba_addr[2] = 22'h001234;
    ba_rd = 4'b0100;
    drain("single_drain", 30);
    got_i = (ack_log.size() > 0) ? ack_log[0] : -1;
    check_val("single_ack_bank", got_i, 2);
    check_val("single_w0", (word_log.size() > 0) ? word_log[0] : 16'hxxxx, 16'hA1B2);
    check_val("single_w1", (word_log.size() > 1) ? word_log[1] : 16'hxxxx, 16'hC3D4);

    // All four banks held: rotation must start at bank 0 after reset.
    do_reset();
    lat_fix = 0;
    ack_log.delete();
    for (int i = 0; i < 4; i++) ba_addr[i] = AW'($urandom);
    hold_all = 1;
    ba_rd = 4'b1111;
    n = 0;
    while (ack_log.size() < 5 && n < 200) begin cycle(); n++; end
    hold_all = 0;
    ba_rd = '0;
    for (int i = 0; i < 5; i++) begin
      got_i = (ack_log.size() > i) ? ack_log[i] : -1;
      check_val($sformatf("rr_order%0d", i), got_i, exp_order[i]);
    end
    drain("rr_drain", 50);

    // Download: bank 0 waits while the write goes through.
    lat_fix = 2;
    ack0_before = n_ack[0];
    prdy_before = n_prog_rdy;
    downloading = 1'b1;
    ba_addr[0] = AW'($urandom);
    ba_rd = 4'b0001;
    prog_we = 1'b1; prog_addr = 22'h000010; prog_ba = 2'd3;
    prog_data = 16'hBEEF; prog_mask = 2'b01;
    repeat (20) cycle();
    check_val("dl_prog_rdy", n_prog_rdy, prdy_before + 1);
    check_val("dl_wr_addr", 32'(last_wr_addr), 32'h00C00010);
    check_val("dl_wr_dm", 32'(last_wr_dm), 32'({16'hBEEF, 2'b01}));
    check_val("dl_no_ack0", n_ack[0], ack0_before);
    downloading = 1'b0;
    drain("dl_drain", 30);
    check_val("dl_ack0_after", n_ack[0], ack0_before + 1);

    // Address wrap within the burst.
    rdaddr_log.delete();
    ba_addr[1] = 22'h3FFFFF;
    ba_rd = 4'b0010;
    drain("wrap_drain", 30);
    check_val("wrap_a0", (rdaddr_log.size() > 0) ? 32'(rdaddr_log[0]) : 32'hx, 32'h007FFFFF);
    check_val("wrap_a1", (rdaddr_log.size() > 1) ? 32'(rdaddr_log[1]) : 32'hx, 32'h00400000);

    // Write and bank 3 read arrive together: write first.
    ack_log.delete();
    prog_we = 1'b1; prog_addr = AW'($urandom); prog_ba = 2'($urandom);
    prog_data = 16'($urandom); prog_mask = 2'b00;
    ba_addr[3] = AW'($urandom);
    ba_rd = 4'b1000;
    drain("prio_drain", 40);
    check_val("prio_first", (ack_log.size() > 0) ? ack_log[0] : -1, 4);
    check_val("prio_second", (ack_log.size() > 1) ? ack_log[1] : -1, 3);

    // Reset after the first word of a burst: no ba_rdy, then normal service.
    lat_fix = 3;
    ba_addr[0] = AW'($urandom);
    ba_rd = 4'b0001;
    saw = 0;
    n = 0;
    while (!saw && n < 30) begin cycle(); saw = (ba_dst != 4'b0); n++; end
    check_val("mid_dst_seen", 32'(saw), 32'd1);
    rdy_before = n_rdy;
    rst = 1'b1;
    ba_rd = '0;
    cycle();
    rst = 1'b0;
    repeat (8) cycle();
    check_val("mid_no_rdy", n_rdy, rdy_before);
    ba_addr[1] = AW'($urandom);
    ba_rd = 4'b0010;
    drain("mid_fresh_drain", 30);
    check_val("mid_fresh_rdy", n_rdy, rdy_before + 1);

    // Randomized traffic with varying latency, downloads and stray mem_ok pulses.
    lat_fix = 0;
    gen_rd = 1; gen_prog = 1; gen_dl = 1; spurious = 1;
    repeat (3000) cycle();
    gen_rd = 0; gen_prog = 0; gen_dl = 0; spurious = 0;
    downloading = 1'b0;
    drain("rand_drain", 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1);
  end

endmodule
